// File: rtl/frame_scanout_pkg.sv
// frame_scanout_pkg: shared graphics constants, pixel packing and scanout FSM encoding.
package frame_scanout_pkg;
   localparam int DEF_WIDTH      = 4;
   localparam int DEF_HEIGHT     = 3;
   localparam int DEF_COLOR_BITS = 8;
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
   typedef struct packed {
      logic [DEF_COLOR_BITS-1:0] r;
      logic [DEF_COLOR_BITS-1:0] g;
      logic [DEF_COLOR_BITS-1:0] b;
   } pixel_t;
endpackage

// File: rtl/scanout_fifo.sv
// scanout_fifo: 2-entry FIFO holding tagged pixels between the framebuffer and the output port.
module scanout_fifo #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic [1:0]    count
);
   logic [DW-1:0] mem [2];
   logic wp, rp, pop_ok, push_ok;
   assign pop_ok  = pop && count != 2'd0;
   assign push_ok = push && (count != 2'd2 || pop_ok);
   assign dout    = mem[rp];
   always_ff @(posedge clk) begin
      if (reset) begin
         wp     <= 1'b0;
         rp     <= 1'b0;
         count  <= 2'd0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else begin
         if (push_ok) begin
            mem[wp] <= din;
            wp      <= ~wp;
         end
         if (pop_ok) rp <= ~rp;
         count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end
endmodule

// File: rtl/frame_scanout.sv
// frame_scanout: raster-scans a framebuffer into a valid/ready pixel stream with a 2-deep skid FIFO.
module frame_scanout
   import frame_scanout_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int HEIGHT     = DEF_HEIGHT,
   parameter int COLOR_BITS = DEF_COLOR_BITS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic                    rd_en,
   output logic [HEIGHT+WIDTH-1:0] rd_addr,
   input  logic [3*COLOR_BITS-1:0] rd_data,
   output logic                    px_valid,
   input  logic                    px_ready,
   output logic [3*COLOR_BITS-1:0] px_data,
   output logic [WIDTH-1:0]        px_x,
   output logic [HEIGHT-1:0]       px_y,
   output logic                    px_eol,
   output logic                    px_eof,
   output logic                    busy,
   output logic                    frame_done
);
   localparam int AW = HEIGHT + WIDTH;
   localparam int DW = AW + 3 * COLOR_BITS;
   state_t state, state_n;
   logic [AW-1:0] addr, addr_q;
   logic rd_q, pop, room, drained;
   logic [1:0] occ;
   logic [DW-1:0] head;
   assign pop      = px_valid && px_ready;
   assign px_valid = occ != 2'd0;
   // occupancy plus the read still in flight, less this cycle's pop, must leave a free slot
   assign room     = {1'b0, occ} + {2'b0, rd_q} - {2'b0, pop} < 3'd2;
   assign drained  = !rd_q && (occ == 2'd0 || (occ == 2'd1 && pop));
   assign rd_en    = state == SCAN && room;
   assign rd_addr  = addr;
   assign {px_y, px_x, px_data} = head;
   assign px_eol     = px_valid && &px_x;
   assign px_eof     = px_eol && &px_y;
   assign busy       = state != IDLE;
   assign frame_done = state == DONE;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start ? SCAN : IDLE;
         SCAN:    state_n = (rd_en && &addr) ? DRAIN : SCAN;
         DRAIN:   state_n = drained ? DONE : DRAIN;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         addr   <= '0;
         addr_q <= '0;
         rd_q   <= 1'b0;
      end else begin
         state  <= state_n;
         rd_q   <= rd_en;
         addr_q <= addr;
         if (state == IDLE) addr <= '0;
         else if (rd_en) addr <= addr + 1'b1;
      end
   end
   scanout_fifo #(.DW(DW)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rd_q),
      .din   ({addr_q, rd_data}),
      .pop   (pop),
      .dout  (head),
      .count (occ)
   );
endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout: random-stimulus bench comparing scanout against a raster-order reference.
module tb_frame_scanout;
   localparam int N = 128;
   logic clk = 0, reset, start, px_ready, start2;
   logic rd_en, px_valid, px_eol, px_eof, busy, frame_done;
   logic [6:0] rd_addr;
   logic [23:0] rd_data, px_data;
   logic [3:0] px_x;
   logic [2:0] px_y;
   logic rd_en2, px_valid2, px_eol2, px_eof2, busy2, frame_done2;
   logic [1:0] rd_addr2;
   logic [23:0] rd_data2, px_data2;
   logic px_x2, px_y2;
   logic [23:0] fb [N];
   int total = 0, bad = 0, cyc = 0;
   int exp_idx, issued, xfers, done_n, done_cyc, first_cyc, last_cyc, stall_left, stall_n, rmode, done2_n;
   bit mon_en = 0, held = 0, mon2_en = 0;
   logic [30:0] hold_val;
   logic [26:0] q2 [$];

   frame_scanout dut (
      .clk(clk), .reset(reset), .start(start), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data), .px_x(px_x), .px_y(px_y),
      .px_eol(px_eol), .px_eof(px_eof), .busy(busy), .frame_done(frame_done));
   frame_scanout #(.WIDTH(1), .HEIGHT(1), .COLOR_BITS(8)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
      .px_valid(px_valid2), .px_ready(1'b1), .px_data(px_data2), .px_x(px_x2), .px_y(px_y2),
      .px_eol(px_eol2), .px_eof(px_eof2), .busy(busy2), .frame_done(frame_done2));

   always #5 clk = ~clk;
   initial forever @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // framebuffer model: data valid in the cycle after the read strobe, junk otherwise
   initial forever begin
      logic rq, rq2;
      logic [6:0] ra;
      logic [1:0] ra2;
      @(negedge clk);
      rq = rd_en; ra = rd_addr; rq2 = rd_en2; ra2 = rd_addr2;
      @(posedge clk);
      #1;
      rd_data  = rq ? fb[ra] : 24'($urandom);
      rd_data2 = rq2 ? {3{6'h30, ra2}} : 24'($urandom);
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rmode == 1) px_ready = $urandom_range(0, 99) < 30;
      else if (rmode == 2 && px_valid && px_x == 4'd3 && px_y == 3'd0 && stall_left > 0) begin
         px_ready = 0;
         stall_left--;
      end else px_ready = 1;
   end

   initial forever begin
      bit xfer;
      @(negedge clk);
      if (mon_en) begin
         xfer = px_valid && px_ready;
         if (held) begin
            check("hold_valid", px_valid, 1);
            check("hold_data", {px_data, px_x, px_y}, hold_val);
         end
         if (rd_en) begin
            check("no_overflow", (issued - xfers - int'(xfer)) < 2, 1);
            check("rd_addr", rd_addr, issued % N);
            issued++;
         end
         if (px_valid && !px_ready && px_x == 4'd3 && px_y == 3'd0) stall_n++;
         if (xfer) begin
            check("px_data", px_data, fb[exp_idx % N]);
            check("px_x", px_x, exp_idx % 16);
            check("px_y", px_y, (exp_idx / 16) % 8);
            check("px_eol", px_eol, exp_idx % 16 == 15);
            check("px_eof", px_eof, exp_idx % N == N - 1);
            if (exp_idx == 0) first_cyc = cyc;
            last_cyc = cyc;
            exp_idx++;
            xfers++;
         end
         if (frame_done) begin
            done_n++;
            done_cyc = cyc;
         end
         held = px_valid && !px_ready;
         hold_val = {px_data, px_x, px_y};
      end
      if (mon2_en) begin
         if (px_valid2) q2.push_back({px_eof2, px_y2, px_x2, px_data2});
         if (frame_done2) done2_n++;
      end
   end

   task automatic check_idle(input string tag);
      check({tag, "_rd_en"}, rd_en, 0);
      check({tag, "_rd_addr"}, rd_addr, 0);
      check({tag, "_px_valid"}, px_valid, 0);
      check({tag, "_px_data"}, px_data, 0);
      check({tag, "_px_x"}, px_x, 0);
      check({tag, "_px_y"}, px_y, 0);
      check({tag, "_px_eol"}, px_eol, 0);
      check({tag, "_px_eof"}, px_eof, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_frame_done"}, frame_done, 0);
   endtask

   task automatic fill_fb(input bit ident);
      for (int a = 0; a < N; a++) fb[a] = ident ? 24'(a) : 24'($urandom);
   endtask

   // call at #1 after a rising edge; start is high for the cycle numbered t0
   task automatic run_frame(input int mode, input bit timing, input int restart_at, input int reset_at);
      int t0;
      bit fin;
      exp_idx = 0; issued = 0; xfers = 0; done_n = 0; held = 0;
      stall_left = 5; stall_n = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
      rmode = mode; mon_en = 1; fin = 0;
      start = 1;
      t0 = cyc;
      @(posedge clk);
      #1;
      start = 0;
      check("busy_on", busy, 1);
      for (int k = 0; k < 3000 && !fin; k++) begin
         start = restart_at != 0 && cyc == t0 + restart_at;
         if (reset_at != 0 && cyc == t0 + reset_at) begin
            reset = 1;
            mon_en = 0;
            @(posedge clk);
            #1;
            reset = 0;
            @(negedge clk);
            check_idle("abort");
            @(posedge clk);
            #1;
            return;
         end
         if (done_n != 0 && cyc > done_cyc + 4) fin = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      start = 0;
      mon_en = 0;
      check("timeout", fin, 1);
      check("xfers", xfers, N);
      check("done_count", done_n, 1);
      check("busy_off", busy, 0);
      if (mode == 2) check("stall_cycles", stall_n, 5);
      if (timing) begin
         check("first_px", first_cyc, t0 + 3);
         check("last_px", last_cyc, t0 + 2 + N);
         check("done_at", done_cyc, t0 + 3 + N);
      end
   endtask

   initial begin
      reset = 1; start = 0; start2 = 0; px_ready = 1; rmode = 0; done2_n = 0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      reset = 0;
      @(posedge clk);
      #1;
      fill_fb(1);
      run_frame(0, 1, 0, 0);
      fill_fb(0);
      run_frame(2, 0, 0, 0);
      fill_fb(0);
      run_frame(1, 0, 0, 0);
      fill_fb(0);
      run_frame(1, 0, 0, 0);
      fill_fb(0);
      run_frame(0, 1, 10, 0);
      fill_fb(0);
      run_frame(0, 0, 0, 20);
      fill_fb(0);
      run_frame(0, 1, 0, 0);
      mon2_en = 1;
      for (int f = 0; f < 2; f++) begin
         start2 = 1;
         @(posedge clk);
         #1;
         start2 = 0;
         for (int k = 0; k < 100 && done2_n <= f; k++) begin
            @(posedge clk);
            #1;
         end
      end
      mon2_en = 0;
      check("small_done", done2_n, 2);
      check("small_count", q2.size(), 8);
      for (int i = 0; i < 8 && i < q2.size(); i++) begin
         logic [1:0] p;
         p = 2'(i % 4);
         check("small_px", q2[i], {p == 2'd3, p[1], p[0], {3{6'h30, p}}});
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
